// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: CPU request/response handshake plus the single-port
// instruction memory read bus. master = fetch unit, slave = CPU/memory side.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] op_code;
    logic [DATA_W-1:0] arg1;
    logic [DATA_W-1:0] arg2;
    logic              instr_valid;
    logic              instr_ack;
    logic              busy;

    modport master (
        input  pc, pc_valid, mem_rdata, instr_ack,
        output mem_en, mem_addr, op_code, arg1, arg2, instr_valid, busy
    );

    modport slave (
        output pc, pc_valid, mem_rdata, instr_ack,
        input  mem_en, mem_addr, op_code, arg1, arg2, instr_valid, busy
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads opcode + two argument bytes from a
// synchronous byte memory. Optional operand reuse under IFETCH_REUSE_EN.
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_F2, S_F3, S_VALID} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] op_code_q, op_code_d;
    logic [DATA_W-1:0] arg1_q, arg1_d;
    logic [DATA_W-1:0] arg2_q, arg2_d;
    logic              accept;

`ifdef IFETCH_REUSE_EN
    // Reuse decision is taken at acceptance and acted on in F0, which then
    // skips its memory read.
    typedef enum logic [1:0] {R_NONE, R_SAME, R_NEXT} reuse_t;
    logic   hold_q, hold_d;
    reuse_t reuse_q, reuse_d;
`endif

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        op_code_d    = op_code_q;
        arg1_d       = arg1_q;
        arg2_d       = arg2_q;
        accept       = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_addr = '0;
`ifdef IFETCH_REUSE_EN
        reuse_d      = reuse_q;
`endif
        case (state_q)
            S_IDLE: accept = bus.pc_valid;
            S_F0: begin
                state_d = S_F1;
`ifdef IFETCH_REUSE_EN
                if (reuse_q == R_SAME) begin
                    state_d = S_VALID;
                    reuse_d = R_NONE;
                end else if (reuse_q == R_NEXT) begin
                    op_code_d = arg1_q;
                    arg1_d    = arg2_q;
                    state_d   = S_F2;
                end else begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base_q;
                end
`else
                bus.mem_en   = 1'b1;
                bus.mem_addr = base_q;
`endif
            end
            S_F1: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = base_q + ADDR_W'(1);
                op_code_d    = bus.mem_rdata;
                state_d      = S_F2;
            end
            S_F2: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = base_q + ADDR_W'(2);
`ifdef IFETCH_REUSE_EN
                if (reuse_q != R_NEXT) arg1_d = bus.mem_rdata;
                reuse_d = R_NONE;
`else
                arg1_d = bus.mem_rdata;
`endif
                state_d = S_F3;
            end
            S_F3: begin
                arg2_d  = bus.mem_rdata;
                state_d = S_VALID;
            end
            S_VALID: begin
                if (bus.instr_ack) begin
                    accept  = bus.pc_valid;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            base_d  = bus.pc;
            state_d = S_F0;
`ifdef IFETCH_REUSE_EN
            if (hold_q && bus.pc == base_q)
                reuse_d = R_SAME;
            else if (hold_q && bus.pc == base_q + ADDR_W'(1))
                reuse_d = R_NEXT;
            else
                reuse_d = R_NONE;
`endif
        end

`ifdef IFETCH_REUSE_EN
        hold_d = hold_q | (state_d == S_VALID);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            op_code_q <= '0;
            arg1_q    <= '0;
            arg2_q    <= '0;
`ifdef IFETCH_REUSE_EN
            hold_q    <= 1'b0;
            reuse_q   <= R_NONE;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            op_code_q <= op_code_d;
            arg1_q    <= arg1_d;
            arg2_q    <= arg2_d;
`ifdef IFETCH_REUSE_EN
            hold_q    <= hold_d;
            reuse_q   <= reuse_d;
`endif
        end
    end

    assign bus.op_code     = op_code_q;
    assign bus.arg1        = arg1_q;
    assign bus.arg2        = arg2_q;
    assign bus.instr_valid = (state_q == S_VALID);
    assign bus.busy        = (state_q == S_F0) || (state_q == S_F1) ||
                             (state_q == S_F2) || (state_q == S_F3);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: synchronous memory model, scoreboard of
// expected instruction bytes, latency / read-count / address-sequence checks.
module tb_instr_fetch;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] a1;
        logic [7:0] a2;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    instr_t     sb[$];
    logic [7:0] addrLog[$];
    int         nChecks = 0;
    int         nFails  = 0;

    // Synchronous read memory: data appears the cycle after the request
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clk) begin
        if (!rst && bus.mem_en) addrLog.push_back(bus.mem_addr);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at a negedge; returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic [7:0] pcVal, input bit withAck);
        instr_t     e;
        logic [7:0] p1;
        logic [7:0] p2;
        p1   = pcVal + 8'd1;
        p2   = pcVal + 8'd2;
        e.op = mem[pcVal];
        e.a1 = mem[p1];
        e.a2 = mem[p2];
        sb.push_back(e);
        addrLog.delete();
        bus.pc        = pcVal;
        bus.pc_valid  = 1'b1;
        bus.instr_ack = withAck;
        @(posedge clk);
        @(negedge clk);
        bus.pc_valid  = 1'b0;
        bus.instr_ack = 1'b0;
    endtask

    task automatic verifyFetch(input string tag, input int expLat, input int expReads,
                               input logic [7:0] firstAddr);
        int         lat;
        instr_t     e;
        logic [7:0] a;
        lat = 0;
        while (!bus.instr_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " reads"}, 32'(addrLog.size()), 32'(expReads));
        for (int i = 0; i < addrLog.size(); i++) begin
            a = firstAddr + 8'(i);
            checkOutput({tag, " addr"}, 32'(addrLog[i]), 32'(a));
        end
        e = sb.pop_front();
        checkOutput({tag, " op_code"}, 32'(bus.op_code), 32'(e.op));
        checkOutput({tag, " arg1"}, 32'(bus.arg1), 32'(e.a1));
        checkOutput({tag, " arg2"}, 32'(bus.arg2), 32'(e.a2));
        checkOutput({tag, " mem_en idle"}, 32'(bus.mem_en), 32'd0);
        checkOutput({tag, " mem_addr idle"}, 32'(bus.mem_addr), 32'd0);
    endtask

    task automatic ackInstr(input string tag);
        bus.instr_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_ack = 1'b0;
        checkOutput({tag, " valid after ack"}, 32'(bus.instr_valid), 32'd0);
        checkOutput({tag, " busy after ack"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, " instr_valid"}, 32'(bus.instr_valid), 32'd0);
        checkOutput({tag, " mem_en"}, 32'(bus.mem_en), 32'd0);
        checkOutput({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " op_code"}, 32'(bus.op_code), 32'd0);
        checkOutput({tag, " arg1"}, 32'(bus.arg1), 32'd0);
        checkOutput({tag, " arg2"}, 32'(bus.arg2), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[8'h10] = 8'h10; mem[8'h11] = 8'h05; mem[8'h12] = 8'h60; mem[8'h13] = 8'hC3;
        mem[8'hFF] = 8'hA7; mem[8'h00] = 8'h01; mem[8'h01] = 8'h02;
        mem[8'h20] = 8'h3A; mem[8'h21] = 8'h4B; mem[8'h22] = 8'h5C;

        bus.pc        = '0;
        bus.pc_valid  = 1'b0;
        bus.instr_ack = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkCleared("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle busy", 32'(bus.busy), 32'd0);

        // Basic fetch from IDLE
        applyStimulus(8'h10, 1'b0);
        checkOutput("basic F0 busy", 32'(bus.busy), 32'd1);
        verifyFetch("basic", 4, 3, 8'h10);

        // Back-to-back: ack and new request in the same cycle
        applyStimulus(8'h20, 1'b1);
        checkOutput("b2b valid drop", 32'(bus.instr_valid), 32'd0);
        checkOutput("b2b busy", 32'(bus.busy), 32'd1);
        checkOutput("b2b mem_en", 32'(bus.mem_en), 32'd1);
        checkOutput("b2b mem_addr", 32'(bus.mem_addr), 32'h20);
        verifyFetch("b2b", 4, 3, 8'h20);
        ackInstr("b2b");

        // Address wrap
        applyStimulus(8'hFF, 1'b0);
        verifyFetch("wrap", 4, 3, 8'hFF);
        ackInstr("wrap");

        // Reset in F2 abandons the fetch
        applyStimulus(8'h10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst F2 addr", 32'(bus.mem_addr), 32'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkCleared("midrst");
        void'(sb.pop_front());
        applyStimulus(8'h10, 1'b0);
        verifyFetch("after rst", 4, 3, 8'h10);

`ifdef IFETCH_REUSE_EN
        applyStimulus(8'h11, 1'b1);
        checkOutput("reuse next valid drop", 32'(bus.instr_valid), 32'd0);
        verifyFetch("reuse next", 3, 1, 8'h13);
        applyStimulus(8'h11, 1'b1);
        verifyFetch("reuse same", 1, 0, 8'h11);
`else
        applyStimulus(8'h11, 1'b1);
        checkOutput("no reuse valid drop", 32'(bus.instr_valid), 32'd0);
        verifyFetch("no reuse", 4, 3, 8'h11);
`endif
        ackInstr("final");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer between the byte-wide synchronous instruction memory and `cpu`. On a fetch request carrying the CPU's program counter, it reads the opcode byte and the two following bytes over one single-port memory interface and presents them as `op_code`, `arg1` and `arg2` with a valid/ack handshake. It replaces the testbench-side `mem[pc]`, `mem[pc+1]`, `mem[pc+2]` lookup with a synthesizable, cycle-accurate fetch path.

## Interface
- `ADDR_W`, default 8: width of program counter and memory address; all address arithmetic is modulo 2^ADDR_W.
- `DATA_W`, default 8: memory word and instruction byte width.

- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset; synchronous and active-high.
- `pc`  in  ADDR_W  address of the opcode to fetch.
- `pc_valid`  in  1  fetch request; sampled only in IDLE or VALID (with `instr_ack`).
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rdata`  in  DATA_W  read data, valid the cycle after the edge that sampled `mem_en`/`mem_addr`.
- `op_code`  out  DATA_W  byte at `pc`.
- `arg1`  out  DATA_W  byte at `pc+1`.
- `arg2`  out  DATA_W  byte at `pc+2`.
- `instr_valid`  out  1  `op_code`/`arg1`/`arg2` are complete and stable.
- `instr_ack`  in  1  CPU has consumed the instruction.
- `busy`  out  1  fetch in progress (states F0–F3).

## Operation
- Registers: `base` (ADDR_W), `op_code`, `arg1`, `arg2`, state. Reset clears all to 0 and enters IDLE; `mem_en`, `instr_valid`, `busy` are 0 in reset.
- States: IDLE, F0, F1, F2, F3, VALID.
- IDLE: on `pc_valid`, `base <= pc`, go to F0.
- F0: `mem_en=1`, `mem_addr=base`; go to F1.
- F1: `mem_en=1`, `mem_addr=base+1`; `op_code <= mem_rdata`; go to F2.
- F2: `mem_en=1`, `mem_addr=base+2`; `arg1 <= mem_rdata`; go to F3.
- F3: `mem_en=0`; `arg2 <= mem_rdata`; go to VALID.
- VALID: `instr_valid=1`; outputs held. On `instr_ack`: if `pc_valid` is also high, accept new `pc` exactly as IDLE does (back-to-back, no idle cycle); otherwise go to IDLE.
- `pc_valid` in F0–F3, or in VALID without `instr_ack`, is ignored; the requester must hold it.
- `mem_addr` is 0 whenever `mem_en=0`.
- Address wrap: `base+1`, `base+2` truncate to ADDR_W (e.g. base 0xFF -> 0x00, 0x01).
- `op_code`/`arg1`/`arg2` are undefined to the consumer while `instr_valid=0`; they retain their last values.

## Timing
- Request accepted at edge T -> `instr_valid` rises after edge T+4 (baseline latency 4 cycles).
- Memory is read on exactly 3 consecutive cycles per full fetch; no read in IDLE, F3, VALID.
- `instr_valid` falls after the edge where `instr_ack` is sampled high.
- `rst` at any edge, including mid-fetch, overrides all transitions: next cycle IDLE, all outputs 0, any pending fetch is abandoned.

## Configuration
- `IFETCH_REUSE_EN` defined: a `hold` flag is set on entering VALID and cleared by reset. On acceptance with `hold=1`:
  - `pc == base`: no memory read; go directly to VALID (`instr_valid` after edge T+1).
  - `pc == base+1`: `op_code <= arg1`, `arg1 <= arg2`, `base <= pc`, jump to F2, which fetches only `pc+2` (`instr_valid` after edge T+3, 1 memory read).
  - Otherwise, full fetch as baseline.
- `IFETCH_REUSE_EN` undefined: every accepted request performs a full 3-read fetch; no `hold` flag is built.

## Test plan
- Reset: assert `rst` for 2 cycles -> `instr_valid=0`, `mem_en=0`, `busy=0`, `op_code`/`arg1`/`arg2` = 0.
- Basic fetch: mem[0x10..0x12]=0x10,0x05,0x60; `pc`=0x10 -> `mem_addr` 0x10,0x11,0x12 on consecutive cycles; `instr_valid` 4 cycles later with `op_code`=0x10, `arg1`=0x05, `arg2`=0x60.
- Wrap: mem[0xFF]=0xA7, mem[0x00]=0x01, mem[0x01]=0x02; `pc`=0xFF -> reads 0xFF,0x00,0x01; outputs 0xA7/0x01/0x02.
- Back-to-back: in VALID, raise `instr_ack` and `pc_valid` (`pc`=0x20) together -> `instr_valid` drops the next cycle; F0 issues 0x20 with no IDLE cycle.
- Mid-fetch reset: assert `rst` in F2 -> next cycle IDLE with all outputs 0. A subsequent request for 0x10 completes with the correct bytes.
- With `IFETCH_REUSE_EN`: after fetching 0x10, request 0x11 -> exactly one read, of 0x13; `op_code`=0x05, `arg1`=0x60, `arg2`=mem[0x13]; valid 3 cycles after accept. Request 0x11 again -> zero reads, valid 1 cycle after accept.
